// File: rtl/zap_irq_sync_ctrl.sv
// ---------------------------------------------------------------------------
// zap_irq_sync_ctrl
//
// Interrupt front-end for the core. Each asynchronous interrupt line passes
// through a two-flop synchronizer, optionally a glitch filter, and then
// edge/level qualification into a pending register. Masked pending bits are
// scheduled by fixed priority (lowest index wins). One ID at a time is
// presented to the core, which accepts it with a single-cycle ack.
//
// Build option:
//   ZAP_IRQ_GLITCH_FILTER_EN - when defined, each synchronized line gets a
//   4-bit stability counter. The line must differ from its filtered value
//   for FILTER_CYCLES consecutive cycles before the filtered value follows.
//   When undefined, the synchronized value is used directly.
//
// Ports:
//   i_clk        core clock
//   i_reset      synchronous, active-high reset
//   i_irq_async  raw asynchronous interrupt lines [NUM_SRC]
//   i_edge_mode  per source: 1 = rising-edge, 0 = level [NUM_SRC]
//   i_mask       per source: 1 = masked [NUM_SRC]
//   i_ack        single-cycle pulse accepting the presented ID
//   o_irq        registered interrupt request to the core
//   o_irq_id     registered ID of the presented source [IDW]
//   o_pending    registered raw pending vector, unmasked [NUM_SRC]
//
// FSM states:
//   state     | meaning
//   ST_IDLE   | no request; pick the lowest eligible source if any
//   ST_ASSERT | o_irq high, ID frozen; wait for ack or withdrawal
//   ST_GAP    | one cycle of o_irq low after an ack
// ---------------------------------------------------------------------------
module zap_irq_sync_ctrl #(
  parameter  int NUM_SRC       = 8,
  parameter  int FILTER_CYCLES = 4,
  localparam int IDW           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_SRC-1:0] i_irq_async,
  input  logic [NUM_SRC-1:0] i_edge_mode,
  input  logic [NUM_SRC-1:0] i_mask,
  input  logic               i_ack,
  output logic               o_irq,
  output logic [IDW-1:0]     o_irq_id,
  output logic [NUM_SRC-1:0] o_pending
);

  if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_chk_num_src
    $error("zap_irq_sync_ctrl: NUM_SRC must be 1..32");
  end
  if (FILTER_CYCLES < 2 || FILTER_CYCLES > 15) begin : g_chk_filter
    $error("zap_irq_sync_ctrl: FILTER_CYCLES must be 2..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t             state_q;
  logic               irq_q;
  logic [IDW-1:0]     irq_id_q;

  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] flt;
  logic [NUM_SRC-1:0] hist_q;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [IDW-1:0]     win_id;
  logic               ack_acc;
  logic               cur_elig;

  // Two-flop synchronizer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_irq_async;
      sync2_q <= sync1_q;
    end
  end

`ifdef ZAP_IRQ_GLITCH_FILTER_EN
  logic [3:0]         cnt_q [NUM_SRC];
  logic [NUM_SRC-1:0] flt_q;

  // The filtered value only follows the synchronized line after it has
  // disagreed for FILTER_CYCLES cycles in a row; any agreement restarts.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flt_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (sync2_q[i] != flt_q[i]) begin
          if (cnt_q[i] == 4'(FILTER_CYCLES - 1)) begin
            flt_q[i] <= sync2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + 4'd1;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign flt = flt_q;
`else
  assign flt = sync2_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) hist_q <= '0;
    else         hist_q <= flt;
  end

  assign rise     = flt & ~hist_q;
  assign elig     = pending_q & ~i_mask;
  assign ack_acc  = (state_q == ST_ASSERT) && i_ack;
  assign cur_elig = elig[irq_id_q];

  // Edge mode: a new rising edge wins over a same-cycle ack clear.
  // Level mode: pending simply tracks the (filtered) line.
  always_comb begin
    clr       = '0;
    pending_d = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i]       = ack_acc && (irq_id_q == IDW'(i));
      pending_d[i] = i_edge_mode[i] ? (rise[i] | (pending_q[i] & ~clr[i]))
                                    : flt[i];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // Lowest-index eligible source; scanning downward leaves the lowest.
  always_comb begin
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) win_id = IDW'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|elig) begin
            irq_id_q <= win_id;
            irq_q    <= 1'b1;
            state_q  <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          // Ack beats withdrawal when both happen in the same cycle.
          if (i_ack) begin
            irq_q   <= 1'b0;
            state_q <= ST_GAP;
          end else if (!cur_elig) begin
            irq_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          irq_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_irq     = irq_q;
  assign o_irq_id  = irq_id_q;
  assign o_pending = pending_q;

endmodule

// File: tb/tb_zap_irq_sync_ctrl.sv
module tb_zap_irq_sync_ctrl;

`ifdef ZAP_IRQ_GLITCH_FILTER_EN
  localparam int FX = 4;
`else
  localparam int FX = 0;
`endif
  // Input pulse width long enough to pass the filter (1 cycle without it).
  localparam int W = FX + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq;
  logic [7:0] edge_m;
  logic [7:0] mask;
  logic       ack;
  logic       o_irq;
  logic [2:0] o_id;
  logic [7:0] pend;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  zap_irq_sync_ctrl #(.NUM_SRC(8), .FILTER_CYCLES(4)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_irq_async (irq),
    .i_edge_mode (edge_m),
    .i_mask      (mask),
    .i_ack       (ack),
    .o_irq       (o_irq),
    .o_irq_id    (o_id),
    .o_pending   (pend)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stepn(input int n);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = '0; ack = 1'b0; mask = '0; edge_m = 8'hFD;
    stepn(3);
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL rst_irq: got %b expected 0", o_irq); end
    vecs++; if (o_id !== 3'd0) begin errs++; $display("FAIL rst_id: got %0d expected 0", o_id); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL rst_pend: got %h expected 00", pend); end
    rst = 1'b0;
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL idle_ack_irq: got %b expected 0", o_irq); end
  endtask

  task automatic test_edge_basic();
    irq[3] = 1'b1; stepn(W); irq[3] = 1'b0;
    step();
    vecs++; if (pend[3] !== 1'b0) begin errs++; $display("FAIL e3_pend_early: got %b expected 0", pend[3]); end
    step();
    vecs++; if (pend !== 8'h08) begin errs++; $display("FAIL e3_pend: got %h expected 08", pend); end
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL e3_irq_early: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b1) begin errs++; $display("FAIL e3_irq: got %b expected 1", o_irq); end
    vecs++; if (o_id !== 3'd3) begin errs++; $display("FAIL e3_id: got %0d expected 3", o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL e3_ack_irq: got %b expected 0", o_irq); end
    vecs++; if (pend !== 8'h00) begin errs++; $display("FAIL e3_ack_pend: got %h expected 00", pend); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL e3_gap_irq: got %b expected 0", o_irq); end
  endtask

  task automatic test_priority();
    irq = 8'h24; stepn(W); irq = 8'h00;
    stepn(2);
    vecs++; if (pend !== 8'h24) begin errs++; $display("FAIL pri_pend: got %h expected 24", pend); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd2) begin errs++; $display("FAIL pri_first: got irq=%b id=%0d expected irq=1 id=2", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0 || pend !== 8'h20) begin errs++; $display("FAIL pri_ack: got irq=%b pend=%h expected irq=0 pend=20", o_irq, pend); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL pri_gap: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd5) begin errs++; $display("FAIL pri_second: got irq=%b id=%0d expected irq=1 id=5", o_irq, o_id); end
    // Higher-priority source arrives while 5 is presented: ID must stay 5.
    irq[2] = 1'b1; stepn(W); irq[2] = 1'b0;
    stepn(3);
    vecs++; if (pend !== 8'h24) begin errs++; $display("FAIL pri_frz_pend: got %h expected 24", pend); end
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd5) begin errs++; $display("FAIL pri_frozen: got irq=%b id=%0d expected irq=1 id=5", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    stepn(2);
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd2) begin errs++; $display("FAIL pri_third: got irq=%b id=%0d expected irq=1 id=2", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    step();
    vecs++; if (o_irq !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL pri_done: got irq=%b pend=%h expected irq=0 pend=00", o_irq, pend); end
  endtask

  task automatic test_level();
    irq[1] = 1'b1; stepn(W);
    stepn(2);
    vecs++; if (pend !== 8'h02) begin errs++; $display("FAIL lvl_pend: got %h expected 02", pend); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd1) begin errs++; $display("FAIL lvl_irq: got irq=%b id=%0d expected irq=1 id=1", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0 || pend[1] !== 1'b1) begin errs++; $display("FAIL lvl_ack: got irq=%b pend1=%b expected irq=0 pend1=1", o_irq, pend[1]); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL lvl_gap: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd1) begin errs++; $display("FAIL lvl_reassert: got irq=%b id=%0d expected irq=1 id=1", o_irq, o_id); end
    irq[1] = 1'b0;
    stepn(FX + 3);
    vecs++; if (o_irq !== 1'b1 || pend[1] !== 1'b0) begin errs++; $display("FAIL lvl_drop_pend: got irq=%b pend1=%b expected irq=1 pend1=0", o_irq, pend[1]); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL lvl_withdraw: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL lvl_idle: got %b expected 0", o_irq); end
  endtask

  task automatic test_mask();
    irq[0] = 1'b1; stepn(W); irq[0] = 1'b0;
    stepn(3);
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd0) begin errs++; $display("FAIL msk_irq: got irq=%b id=%0d expected irq=1 id=0", o_irq, o_id); end
    mask[0] = 1'b1; step();
    vecs++; if (o_irq !== 1'b0 || pend[0] !== 1'b1) begin errs++; $display("FAIL msk_withdraw: got irq=%b pend0=%b expected irq=0 pend0=1", o_irq, pend[0]); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL msk_hold: got %b expected 0", o_irq); end
    mask[0] = 1'b0; step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd0) begin errs++; $display("FAIL msk_unmask: got irq=%b id=%0d expected irq=1 id=0", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL msk_ack: got irq=%b pend=%h expected irq=0 pend=00", o_irq, pend); end
    step();
  endtask

  task automatic test_back_to_back();
    irq[4] = 1'b1; stepn(W); irq[4] = 1'b0;
    stepn(3);
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd4) begin errs++; $display("FAIL b2b_first: got irq=%b id=%0d expected irq=1 id=4", o_irq, o_id); end
    stepn(2 * FX + 2);
    // Second edge lands its pending-set on the same edge that takes the ack.
    irq[4] = 1'b1; stepn(W); irq[4] = 1'b0;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    vecs++; if (o_irq !== 1'b0 || pend[4] !== 1'b1) begin errs++; $display("FAIL b2b_setwins: got irq=%b pend4=%b expected irq=0 pend4=1", o_irq, pend[4]); end
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL b2b_gap: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd4) begin errs++; $display("FAIL b2b_again: got irq=%b id=%0d expected irq=1 id=4", o_irq, o_id); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; ack = 1'b1; step();
    vecs++; if (o_irq !== 1'b0 || o_id !== 3'd0 || pend !== 8'h00) begin errs++; $display("FAIL mid_rst: got irq=%b id=%0d pend=%h expected irq=0 id=0 pend=00", o_irq, o_id, pend); end
    rst = 1'b0; ack = 1'b0; stepn(2);
    vecs++; if (o_irq !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL mid_after: got irq=%b pend=%h expected irq=0 pend=00", o_irq, pend); end
  endtask

`ifdef ZAP_IRQ_GLITCH_FILTER_EN
  task automatic test_glitch_filter();
    irq[6] = 1'b1; stepn(3); irq[6] = 1'b0;
    stepn(12);
    vecs++; if (o_irq !== 1'b0 || pend !== 8'h00) begin errs++; $display("FAIL flt_short: got irq=%b pend=%h expected irq=0 pend=00", o_irq, pend); end
    irq[6] = 1'b1; stepn(6); irq[6] = 1'b0;
    step();
    vecs++; if (o_irq !== 1'b0) begin errs++; $display("FAIL flt_e6: got %b expected 0", o_irq); end
    step();
    vecs++; if (o_irq !== 1'b1 || o_id !== 3'd6) begin errs++; $display("FAIL flt_e7: got irq=%b id=%0d expected irq=1 id=6", o_irq, o_id); end
    ack = 1'b1; step(); ack = 1'b0;
    stepn(2);
  endtask
`endif

  initial begin
    test_reset();
    test_edge_basic();
    test_priority();
    test_level();
    test_mask();
    test_back_to_back();
    test_reset_mid();
`ifdef ZAP_IRQ_GLITCH_FILTER_EN
    test_glitch_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zap_irq_sync_ctrl.md
Name: zap_irq_sync_ctrl

Overview:
Interrupt front-end controller for the core. Takes NUM_SRC asynchronous interrupt lines and passes each through a two-flop synchronizer. It then qualifies each line as edge- or level-triggered, holds pending state, and applies masks. A fixed-priority scheduler presents one interrupt ID at a time to the core and handshakes with the core's acknowledge. The block sits between the SoC interrupt pins and the core's IRQ input.

Parameters:
NUM_SRC, 8, number of interrupt sources (1..32).
FILTER_CYCLES, 4, glitch-filter stability count (2..15); used only when ZAP_IRQ_GLITCH_FILTER_EN is defined.

Ports:
i_clk  input  1  core clock.
i_reset  input  1  reset, synchronous, active-high.
i_irq_async  input  NUM_SRC  raw asynchronous interrupt lines.
i_edge_mode  input  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static, i_clk domain.
i_mask  input  NUM_SRC  per source: 1 = masked; i_clk domain.
i_ack  input  1  single-cycle pulse from the core accepting the presented ID.
o_irq  output  1  interrupt request to the core, registered.
o_irq_id  output  IDW  ID of the presented source, registered. IDW = (NUM_SRC>1) ? $clog2(NUM_SRC) : 1.
o_pending  output  NUM_SRC  raw pending vector, before masking, registered.

Behaviour:
- Reset: both synchronizer ranks = 0, edge-history regs = 0, o_pending = 0, o_irq = 0, o_irq_id = 0, FSM = IDLE. Reset mid-handshake discards all pending state; an outstanding i_ack is ignored.
- Sync: each line uses two flops reset to 0, giving sync[i]. A 1-cycle history reg sync_d[i] provides rising-edge detection: rise = sync & ~sync_d.
- Pending, edge mode:
  - Set on rise[i].
  - Cleared by an accepted ack for that ID.
  - Set and clear in the same cycle: set wins, so the new edge stays pending.
- Pending, level mode: pending[i] <= sync[i] every cycle. Ack does not clear it.
- Mode change while pending: the new mode's rule applies from the next cycle.
- Eligible vector: elig = pending & ~i_mask. Winner = lowest-index set bit of elig.
- FSM states: IDLE, ASSERT, GAP.
  - IDLE: o_irq = 0. If elig != 0, latch the winner into o_irq_id, set o_irq = 1 and go to ASSERT. An i_ack in IDLE is ignored.
  - ASSERT: o_irq_id is frozen, even if a higher-priority source becomes pending.
    - On i_ack: clear the pending bit of o_irq_id if it is edge mode, set o_irq = 0, go to GAP.
    - Otherwise, if elig[o_irq_id] drops (masked, or level released): withdraw, set o_irq = 0, go to IDLE. No pending bit is changed.
    - i_ack takes precedence over withdrawal in the same cycle.
  - GAP: one cycle with o_irq = 0, then IDLE. This guarantees the core sees o_irq deassert between requests. An i_ack in GAP is ignored.
- Latency without filter: let E0 be the first i_clk edge that samples i_irq_async[i] = 1, with the source unmasked and the FSM in IDLE.
  - sync high after E1.
  - pending high after E2.
  - o_irq = 1 and o_irq_id = i after E3.
- Back-to-back: minimum spacing from ack to the next o_irq rise is 2 cycles (ack edge → GAP → IDLE → ASSERT).
- o_pending mirrors the pending regs; the mask is not applied.

Optional Feature:
ZAP_IRQ_GLITCH_FILTER_EN
- Defined: each source has a 4-bit stability counter after synchronization.
  - The filtered value flt[i] takes sync[i] only after sync[i] != flt[i] for FILTER_CYCLES consecutive cycles.
  - Any return to equality resets the counter to 0.
  - Counters and flt reset to 0.
  - Edge detection and level pending use flt instead of sync.
  - Latency increases by FILTER_CYCLES, so o_irq rises after E3+FILTER_CYCLES.
  - Pulses shorter than FILTER_CYCLES i_clk cycles are dropped.
- Undefined: flt = sync; no counters are instantiated.

Test Plan:
- Source 3, edge mode, unmasked; 1-cycle pulse on i_irq_async[3] sampled at E0 → o_pending[3] = 1 after E2; o_irq = 1, o_irq_id = 3 after E3; i_ack → o_irq = 0 next cycle, o_pending[3] = 0; o_irq stays 0 for the GAP cycle.
- Sources 5 and 2 edge-raised in the same cycle → o_irq_id = 2 first. After its ack and GAP, o_irq_id = 5 and o_irq rises 2 cycles after the first ack.
- Source 1, level mode, held high; ack issued → o_irq re-asserts with ID 1 after GAP. Drop the line while in ASSERT without ack → o_irq falls within 3 cycles, FSM returns to IDLE, no ack required.
- Source 0 presented; set i_mask[0] = 1 before ack → o_irq withdrawn; o_pending[0] stays 1 (edge mode). Unmask → re-presented with ID 0.
- Edge on source 4 in the same cycle as i_ack for ID 4 (edge mode) → o_pending[4] remains 1 and ID 4 is re-presented after GAP. Assert i_reset mid-ASSERT → o_irq = 0, o_irq_id = 0, o_pending = 0 on the next cycle.
- With ZAP_IRQ_GLITCH_FILTER_EN and FILTER_CYCLES = 4: a 3-cycle high pulse → no pending, o_irq stays 0. A 6-cycle high pulse → o_irq = 1 after E7.
